// File: rtl/sobel_window_gen.sv
// Raster-to-3x3 window generator for the Sobel edge filter: two line buffers plus a register window.
// Optional WINDOW_COORD_EN adds out_cx/out_cy carrying the window centre coordinates.
module sobel_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out0,
    output logic [DATA_WIDTH-1:0] out1,
    output logic [DATA_WIDTH-1:0] out2,
    output logic [DATA_WIDTH-1:0] out3,
    output logic [DATA_WIDTH-1:0] out4,
    output logic [DATA_WIDTH-1:0] out5,
    output logic [DATA_WIDTH-1:0] out6,
    output logic [DATA_WIDTH-1:0] out7,
    output logic [DATA_WIDTH-1:0] out8
`ifdef WINDOW_COORD_EN
    ,
    output logic [CNT_WIDTH-1:0]  out_cx,
    output logic [CNT_WIDTH-1:0]  out_cy
`endif
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);

    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];

    logic [CNT_WIDTH-1:0]  col_q, col_d, row_q, row_d;
    logic [DATA_WIDTH-1:0] win_q [9];
    logic [DATA_WIDTH-1:0] win_d [9];
    logic [DATA_WIDTH-1:0] out_q [9];
    logic [DATA_WIDTH-1:0] out_d [9];
    logic                  out_valid_q, out_valid_d;
`ifdef WINDOW_COORD_EN
    logic [CNT_WIDTH-1:0]  cx_q, cx_d, cy_q, cy_d;
`endif

    logic [AW-1:0] lb_idx;
    logic          accept;

    assign lb_idx = col_q[AW-1:0];
    assign accept = in_valid & ~refresh;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
`ifdef WINDOW_COORD_EN
        cx_d        = cx_q;
        cy_d        = cy_q;
`endif
        if (refresh) begin
            col_d = '0;
            row_d = '0;
            for (int i = 0; i < 9; i++) begin
                win_d[i] = '0;
                out_d[i] = '0;
            end
`ifdef WINDOW_COORD_EN
            cx_d = '0;
            cy_d = '0;
`endif
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb2[lb_idx];
            win_d[5] = lb1[lb_idx];
            win_d[8] = in_pixel;

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            // Only fully interior windows are published; earlier columns/rows hold stale data.
            if (row_q >= TWO && col_q >= TWO) begin
                out_valid_d = 1'b1;
                out_d       = win_d;
`ifdef WINDOW_COORD_EN
                cx_d        = col_q - 1'b1;
                cy_d        = row_q - 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
                out_q[i] <= '0;
            end
`ifdef WINDOW_COORD_EN
            cx_q        <= '0;
            cy_q        <= '0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            win_q       <= win_d;
            out_q       <= out_d;
`ifdef WINDOW_COORD_EN
            cx_q        <= cx_d;
            cy_q        <= cy_d;
`endif
        end
    end

    // Line buffers carry no reset; row<2 gating keeps stale contents from ever being published.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[lb_idx] <= lb1[lb_idx];
            lb1[lb_idx] <= in_pixel;
        end
    end

    assign out_valid = out_valid_q;
    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];
    assign out4 = out_q[4];
    assign out5 = out_q[5];
    assign out6 = out_q[6];
    assign out7 = out_q[7];
    assign out8 = out_q[8];
`ifdef WINDOW_COORD_EN
    assign out_cx = cx_q;
    assign out_cy = cy_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 image with pixel = row*16+col.
module tb_sobel_window_gen;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          refresh = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          out_valid;
    logic [DW-1:0] out0, out1, out2, out3, out4, out5, out6, out7, out8;
`ifdef WINDOW_COORD_EN
    logic [CW-1:0] out_cx, out_cy;
`endif

    always #5 clk = ~clk;

    sobel_window_gen #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .refresh(refresh), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(out_valid),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out5(out5), .out6(out6), .out7(out7), .out8(out8)
`ifdef WINDOW_COORD_EN
        , .out_cx(out_cx), .out_cy(out_cy)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    logic [71:0] win_act;
    assign win_act = {out0, out1, out2, out3, out4, out5, out6, out7, out8};

    typedef struct {
        logic        v;
        logic        rf;
        logic [7:0]  pix;
        logic        ev;
        logic [71:0] ew;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    // Window whose bottom-right pixel is (r,c): rows r-2..r, cols c-2..c.
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        for (int k = 0; k < 9; k++)
            w[71-8*k -: 8] = pix_of(r - 2 + k / 3, c - 2 + k % 3);
        return w;
    endfunction

    task automatic step(input logic v, input logic rf, input logic [7:0] pix);
        in_valid = v;
        refresh  = rf;
        in_pixel = pix;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        refresh  = 1'b0;
    endtask

    task automatic send(input int r, input int c, input int gap);
        for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 8'hEE);
            check("gap_valid", 72'(out_valid), 72'(0));
        end
        step(1'b1, 1'b0, pix_of(r, c));
        check($sformatf("valid_%0d_%0d", r, c), 72'(out_valid), 72'(r >= 2 && c >= 2));
        if (r >= 2 && c >= 2) begin
            pulses++;
            check($sformatf("win_%0d_%0d", r, c), win_act, exp_win(r, c));
`ifdef WINDOW_COORD_EN
            check($sformatf("cx_%0d_%0d", r, c), 72'(out_cx), 72'(c - 1));
            check($sformatf("cy_%0d_%0d", r, c), 72'(out_cy), 72'(r - 1));
`endif
        end
    endtask

    task automatic frame(input int max_gap);
        pulses = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        check("pulses_per_frame", 72'(pulses), 72'(24));
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h30, 1'b0, 72'h05_06_07_15_16_17_25_26_27};
        tbl[1] = '{1'b1, 1'b0, 8'h31, 1'b0, 72'h05_06_07_15_16_17_25_26_27};
        tbl[2] = '{1'b1, 1'b0, 8'h32, 1'b1, 72'h10_11_12_20_21_22_30_31_32};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 72'h10_11_12_20_21_22_30_31_32};
        tbl[4] = '{1'b1, 1'b0, 8'h33, 1'b1, 72'h11_12_13_21_22_23_31_32_33};
        tbl[5] = '{1'b1, 1'b0, 8'h34, 1'b1, 72'h12_13_14_22_23_24_32_33_34};
        tbl[6] = '{1'b1, 1'b1, 8'h35, 1'b0, 72'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 72'(out_valid), 72'(0));
        check("rst_win", win_act, 72'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Gapless frame
        frame(0);

        // Line wrap, idle hold and refresh at (3,5) via vector table
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                send(r, c, 0);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].rf, tbl[i].pix);
            check($sformatf("tbl%0d_valid", i), 72'(out_valid), 72'(tbl[i].ev));
            check($sformatf("tbl%0d_win", i), win_act, tbl[i].ew);
        end
        // Restarted frame after refresh must match a clean frame
        frame(0);

        // Two back-to-back frames with random gaps
        frame(5);
        frame(5);

        // Asynchronous reset mid-cycle during row 4
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                send(r, c, 0);
        for (int c = 0; c < 4; c++)
            send(4, c, 0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 72'(out_valid), 72'(0));
        check("arst_win", win_act, 72'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Raster-to-window front end that feeds the 3x3 edge filter.
- Accepts one pixel per valid cycle in raster order: left to right, top to bottom.
- Buffers the two previous image lines and presents a 3x3 neighbourhood on nine parallel outputs, ordered 0 1 2 / 3 4 5 / 6 7 8.
- Produces only fully interior windows; the filter consumes out0..out8 directly.

Parameters:
DATA_WIDTH, 8, bits per pixel
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
CNT_WIDTH, 10, width of column and row counters; must hold IMG_WIDTH-1 and IMG_HEIGHT-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
refresh  in  1  synchronous frame-start clear, active-high
in_valid  in  1  in_pixel is accepted this cycle
in_pixel  in  DATA_WIDTH  raster pixel
out_valid  out  1  window valid pulse
out0..out8  out  DATA_WIDTH each  window pixels: out0..2 = row r-2, out3..5 = row r-1, out6..8 = row r; left to right = columns c-2, c-1, c

Behaviour:
- Reset (rst low): asynchronous reset. It clears:
  - col and row counters
  - 3x3 window registers
  - out_valid and out0..out8, all to 0.
  Line-buffer memory is not reset.
- refresh high at a clock edge: same clear as reset, applied synchronously. Line buffers are untouched.
  - refresh has priority over in_valid; a pixel presented in that cycle is dropped.
- Storage:
  - Two line buffers lb1 (line r-1) and lb2 (line r-2), IMG_WIDTH x DATA_WIDTH each, asynchronous read indexed by col.
  - A 3x3 register window.
- On an accepted pixel (in_valid=1, refresh=0):
  - Window shifts one column left. New right column, top to bottom = lb2[col], lb1[col], in_pixel.
  - lb2[col] <= lb1[col]; lb1[col] <= in_pixel.
  - col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At row IMG_HEIGHT-1 / col IMG_WIDTH-1, both wrap to 0 and the next pixel starts a new frame with no refresh required.
  - out_valid <= 1 exactly when the accepted pixel has row>=2 and col>=2; otherwise 0.
- in_valid=0: window, counters and buffers hold; out_valid <= 0.
- Latency: one clock from accepted pixel (r,c) to out_valid with its window on out0..out8. Window centre out4 = pixel (r-1,c-1).
- out0..out8 hold their last value between pulses; content is meaningful only while out_valid=1.
- Line wrap: the first two pixels of each line refill the window with stale previous-line columns; no out_valid is produced for them.
- Gaps: arbitrary in_valid gaps, including across line and frame ends, do not change results.
- Window pulses per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Reset or refresh mid-frame: the following pixel is treated as (0,0). Stale line-buffer data is never exposed, because row<2 suppresses out_valid.

Optional Feature:
Macro WINDOW_COORD_EN.
- Defined: adds outputs out_cx and out_cy, CNT_WIDTH each, holding the centre coordinates (c-1, r-1) of the window.
  - Registered with the same timing as out0..out8.
  - Reset/refresh value 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, and pixel value = row*16+col.
1. Reset, then stream one gapless frame -> first out_valid one cycle after pixel (2,2) (the 19th accepted), with out0..out8 = 00 01 02 10 11 12 20 21 22 hex. Exactly 24 out_valid pulses per frame.
2. Line wrap: pixels (3,0) and (3,1) -> no out_valid. Pixel (3,2) -> out0..out8 = 10 11 12 20 21 22 30 31 32.
3. Random in_valid gaps of 0-5 cycles over two back-to-back frames -> same 48 windows in the same order as the gapless run. Second frame's first window again 00 01 02 10 11 12 20 21 22.
4. refresh asserted together with in_valid at pixel (3,5), then the frame restarts -> that pixel dropped, outputs cleared next cycle. The restarted frame's first window equals scenario 1's, and no window mixes pre-refresh data.
5. rst pulsed low mid-cycle during row 4 -> out_valid and out0..out8 go to 0 immediately without a clock edge. A fresh frame after release gives scenario 1's results.
6. With WINDOW_COORD_EN defined, full frame -> out_cx/out_cy track (1,1) through (6,4) alongside out4 = cy*16+cx. Without the macro, the build has no out_cx/out_cy ports.
